// File: rtl/seq_mult_if.sv
// Operand/result bundle for the sequential multiplier: request side (start, operands)
// and response side (busy, done pulse, held product).
interface seq_mult_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic                 signed_op;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, signed_op, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, signed_op, a, b,
      output busy, done, product
   );
endinterface

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, unsigned or signed per operation.
// Sign-magnitude core: magnitudes are multiplied, the sign is applied once in DONE.
module seq_mult_param #(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   seq_mult_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_reg, state_next;
   logic [WIDTH:0]       mag_a_reg, mag_a_next;
   logic [WIDTH:0]       mag_b_reg, mag_b_next;
   logic                 neg_reg, neg_next;
   logic [2*WIDTH-1:0]   acc_reg, acc_next;
   logic [2*WIDTH-1:0]   product_reg, product_next;
   logic [CNT_W-1:0]     cnt_reg, cnt_next;
   logic                 done_reg, done_next;

   logic                 a_is_neg, b_is_neg;
   logic [WIDTH:0]       ext_a, ext_b;
   logic [WIDTH:0]       abs_a, abs_b;
   logic [WIDTH:0]       addend;
   logic [WIDTH:0]       partial_sum;

   // One extra magnitude bit keeps |-2^(WIDTH-1)| exact after negation.
   assign a_is_neg = bus.signed_op & bus.a[WIDTH-1];
   assign b_is_neg = bus.signed_op & bus.b[WIDTH-1];
   assign ext_a    = {a_is_neg, bus.a};
   assign ext_b    = {b_is_neg, bus.b};
   assign abs_a    = a_is_neg ? -ext_a : ext_a;
   assign abs_b    = b_is_neg ? -ext_b : ext_b;

   generate
      for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_addend
         assign addend[gi] = mag_a_reg[gi] & mag_b_reg[0];
      end
   endgenerate

   // Upper half plus multiplicand; the carry lands in the top bit and is shifted in below.
   assign partial_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + addend;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         mag_a_reg   <= '0;
         mag_b_reg   <= '0;
         neg_reg     <= 1'b0;
         acc_reg     <= '0;
         product_reg <= '0;
         cnt_reg     <= '0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         mag_a_reg   <= mag_a_next;
         mag_b_reg   <= mag_b_next;
         neg_reg     <= neg_next;
         acc_reg     <= acc_next;
         product_reg <= product_next;
         cnt_reg     <= cnt_next;
         done_reg    <= done_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      mag_a_next   = mag_a_reg;
      mag_b_next   = mag_b_reg;
      neg_next     = neg_reg;
      acc_next     = acc_reg;
      product_next = product_reg;
      cnt_next     = cnt_reg;
      done_next    = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               mag_a_next = abs_a;
               mag_b_next = abs_b;
               neg_next   = bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               acc_next   = '0;
               cnt_next   = '0;
               state_next = CALC;
            end
         end

         CALC: begin
            acc_next   = {partial_sum, acc_reg[WIDTH-1:1]};
            mag_b_next = {1'b0, mag_b_reg[WIDTH:1]};
            cnt_next   = cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(WIDTH - 1)) begin
               state_next = DONE;
            end
         end

         DONE: begin
            // Negating a zero magnitude yields zero, so no special case is needed.
            product_next = neg_reg ? -acc_reg : acc_reg;
            done_next    = 1'b1;
            state_next   = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.busy    = (state_reg != IDLE);
   assign bus.done    = done_reg;
   assign bus.product = product_reg;

endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param at WIDTH=4 and WIDTH=16 against a timer-plus-arithmetic reference.
module tb_seq_mult_param;

   logic clk;
   logic rst;
   bit   chk_en;
   int   n_vec;
   int   n_fail;

   int     m_timer [2];
   longint m_pend  [2];
   longint m_prod  [2];
   bit     m_done  [2];

   seq_mult_if #(.WIDTH(4))  bus4  ();
   seq_mult_if #(.WIDTH(16)) bus16 ();

   seq_mult_param #(.WIDTH(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4.slave)
   );

   seq_mult_param #(.WIDTH(16)) dut16 (
      .clk (clk),
      .rst (rst),
      .bus (bus16.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Plain arithmetic product, reduced to 2*w bits.
   function automatic longint ref_prod(input int w, input longint av, input longint bv, input bit s);
      longint x, y;
      x = av;
      y = bv;
      if (s && av[w-1]) x = av - (longint'(1) << w);
      if (s && bv[w-1]) y = bv - (longint'(1) << w);
      return (x * y) & ((longint'(1) << (2 * w)) - 1);
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // An accepted request occupies the unit for w+1 edges, then the product appears with done.
   task automatic model_step(input int k, input int w, input logic st, input logic s,
                             input longint av, input longint bv);
      if (rst) begin
         m_timer[k] = 0;
         m_prod[k]  = 0;
         m_done[k]  = 1'b0;
      end else begin
         m_done[k] = 1'b0;
         if (m_timer[k] > 0) begin
            m_timer[k]--;
            if (m_timer[k] == 0) begin
               m_prod[k] = m_pend[k];
               m_done[k] = 1'b1;
            end
         end else if (st) begin
            m_pend[k]  = ref_prod(w, av, bv, s);
            m_timer[k] = w + 1;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step(0, 4,  bus4.start,  bus4.signed_op,  longint'(bus4.a),  longint'(bus4.b));
      model_step(1, 16, bus16.start, bus16.signed_op, longint'(bus16.a), longint'(bus16.b));
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("w4 busy",     longint'(bus4.busy),     longint'(m_timer[0] > 0));
         check("w4 done",     longint'(bus4.done),     longint'(m_done[0]));
         check("w4 product",  longint'(bus4.product),  m_prod[0]);
         check("w16 busy",    longint'(bus16.busy),    longint'(m_timer[1] > 0));
         check("w16 done",    longint'(bus16.done),    longint'(m_done[1]));
         check("w16 product", longint'(bus16.product), m_prod[1]);
      end
   end

   task automatic drive(input int k, input logic st, input logic s, input logic [15:0] av,
                        input logic [15:0] bv);
      if (k == 0) begin
         bus4.start     = st;
         bus4.signed_op = s;
         bus4.a         = av[3:0];
         bus4.b         = bv[3:0];
      end else begin
         bus16.start     = st;
         bus16.signed_op = s;
         bus16.a         = av;
         bus16.b         = bv;
      end
   endtask

   function automatic longint prod_of(input int k);
      return (k == 0) ? longint'(bus4.product) : longint'(bus16.product);
   endfunction

   function automatic logic done_of(input int k);
      return (k == 0) ? bus4.done : bus16.done;
   endfunction

   // Called just after a rising edge; returns just after the edge that raised done.
   task automatic run_op(input int k, input logic [15:0] av, input logic [15:0] bv, input logic s,
                         input longint exp, input string name);
      int   w;
      int   n;
      logic got;
      w   = (k == 0) ? 4 : 16;
      n   = 0;
      got = 1'b0;
      drive(k, 1'b1, s, av, bv);
      @(posedge clk);
      #1;
      drive(k, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
      while (n < w + 8 && !got) begin
         @(posedge clk);
         n++;
         #1;
         got = done_of(k);
      end
      check({name, " latency"}, longint'(n), longint'(w + 1));
      check({name, " product"}, prod_of(k), exp);
   endtask

   initial begin
      int nd;
      int last;
      longint seen;
      rst    = 1'b1;
      chk_en = 1'b0;
      n_vec  = 0;
      n_fail = 0;
      drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
      drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;
      check("reset busy",    longint'(bus4.busy),    0);
      check("reset done",    longint'(bus4.done),    0);
      check("reset product", longint'(bus4.product), 0);

      run_op(0, 16'hF, 16'hF, 1'b0, 64'hE1, "unsigned max");
      run_op(0, 16'h8, 16'h8, 1'b1, 64'h40, "signed min*min");
      run_op(0, 16'h8, 16'h7, 1'b1, 64'hC8, "signed min*max");
      run_op(0, 16'h8, 16'h7, 1'b0, 64'h38, "unsigned 8*7");
      run_op(0, 16'h0, 16'hD, 1'b0, 64'h00, "zero operand");
      run_op(0, 16'h1, 16'hF, 1'b1, 64'hFF, "one*minus one");
      run_op(1, 16'h8000, 16'h8000, 1'b1, 64'h40000000, "w16 signed min*min");
      run_op(1, 16'hFFFF, 16'hFFFF, 1'b0, 64'hFFFE0001, "w16 unsigned max");

      // second start during CALC must be ignored
      drive(0, 1'b1, 1'b0, 16'h3, 16'h5);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 16'h3, 16'h5);
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b0, 16'h7, 16'h7);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 16'h7, 16'h7);
      nd   = 0;
      seen = -1;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (bus4.done) begin
            nd++;
            seen = longint'(bus4.product);
         end
      end
      check("busy start done count", longint'(nd), 1);
      check("busy start product", seen, 64'h0F);

      // start held high: one accept per WIDTH+2 cycles
      nd   = 0;
      last = -1;
      drive(0, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
      for (int c = 0; c < 21; c++) begin
         @(posedge clk); #1;
         if (bus4.done) begin
            if (nd > 0) check("b2b period", longint'(c - last), 6);
            last = c;
            nd++;
         end
         drive(0, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
      end
      drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
      check("b2b done count", longint'(nd >= 3), 1);
      repeat (8) @(posedge clk);
      #1;

      // reset two cycles into an operation aborts it
      drive(0, 1'b1, 1'b0, 16'h9, 16'h9);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 16'h9, 16'h9);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort busy",    longint'(bus4.busy),    0);
      check("abort done",    longint'(bus4.done),    0);
      check("abort product", longint'(bus4.product), 0);
      nd = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (bus4.done) nd++;
      end
      check("abort no done", longint'(nd), 0);
      run_op(0, 16'h2, 16'h3, 1'b0, 64'h06, "after abort");

      for (int s = 0; s < 2; s++)
         for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
               run_op(0, 16'(x), 16'(y), s[0], ref_prod(4, longint'(x), longint'(y), s[0]), "w4 exhaustive");

      for (int i = 0; i < 1500; i++) begin
         logic [15:0] ra, rb;
         logic        rs;
         ra = 16'($urandom);
         rb = 16'($urandom);
         rs = 1'($urandom);
         run_op(1, ra, rb, rs, ref_prod(16, longint'(ra), longint'(rb), rs), "w16 random");
      end

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not complete, %0d vectors so far", n_vec);
      $fatal(1, "timeout");
   end

endmodule
